peak_detect_win: RTL and testbench

- Streaming local-maximum detector, the parametrised successor to the 3-point Moore peak detector.
- Sample window width is configurable: W = 2*HALF_WIN+1.
- Adds a runtime amplitude threshold, a refractory hold-off between reported peaks, a valid handshake on input and output, and a sample-index tag on each peak.
- Sits after the sample front-end filter; feeds the event/rate logic downstream.

---
 rtl/peak_detect_win_if.sv | 37 +++
 rtl/peak_detect_win.sv | 120 ++++++++++++
 tb/tb_peak_detect_win.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/peak_detect_win_if.sv
// Sample-in / peak-out bundle for peak_detect_win.
// PEAK_DETECT_PROMINENCE_EN adds the prominence input.
interface peak_detect_win_if #(
  parameter int DATA_IN_BITS = 16,
  parameter int IDX_BITS     = 16
);
  logic                    in_valid;
  logic [DATA_IN_BITS-1:0] in_data;
  logic [DATA_IN_BITS-1:0] threshold;
`ifdef PEAK_DETECT_PROMINENCE_EN
  logic [DATA_IN_BITS-1:0] prominence;
`endif
  logic                    out_valid;
  logic [DATA_IN_BITS-1:0] out_data;
  logic [IDX_BITS-1:0]     out_index;
  logic                    busy;

`ifdef PEAK_DETECT_PROMINENCE_EN
  modport master (
    output in_valid, in_data, threshold, prominence,
    input  out_valid, out_data, out_index, busy
  );
  modport slave (
    input  in_valid, in_data, threshold, prominence,
    output out_valid, out_data, out_index, busy
  );
`else
  modport master (
    output in_valid, in_data, threshold,
    input  out_valid, out_data, out_index, busy
  );
  modport slave (
    input  in_valid, in_data, threshold,
    output out_valid, out_data, out_index, busy
  );
`endif
endinterface

// File: rtl/peak_detect_win.sv
// Streaming windowed local-maximum detector with threshold and hold-off.
// Optional macro PEAK_DETECT_PROMINENCE_EN adds a prominence criterion.
module peak_detect_win #(
  parameter int DATA_IN_BITS = 16,
  parameter int HALF_WIN     = 2,
  parameter int REFRACT      = 8,
  parameter int IDX_BITS     = 16
) (
  input  logic             clk,
  input  logic             reset,
  peak_detect_win_if.slave bus
);
  localparam int W  = 2*HALF_WIN+1;
  localparam int FB = $clog2(W+1);
  localparam int HB = (REFRACT > 0) ? $clog2(REFRACT+1) : 1;

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [DATA_IN_BITS-1:0] r_win [W];
  logic [DATA_IN_BITS-1:0] w_nwin [W];
  logic [IDX_BITS-1:0]     r_cnt;
  logic [FB-1:0]           r_fill;
  logic [HB-1:0]           r_hold;
  logic [1:0]              r_state;
  logic                    r_out_valid;
  logic [DATA_IN_BITS-1:0] r_out_data;
  logic [IDX_BITS-1:0]     r_out_index;

  logic                    w_peak;
  logic                    w_full;
  logic                    w_fire;
  logic [DATA_IN_BITS-1:0] w_ctr;
  logic [IDX_BITS-1:0]     w_cidx;
`ifdef PEAK_DETECT_PROMINENCE_EN
  logic [DATA_IN_BITS-1:0] w_min;
`endif

  // Window as it will look after this beat's shift
  always_comb begin
    w_nwin[0] = bus.in_data;
    for (int k = 1; k < W; k++)
      w_nwin[k] = r_win[k-1];
  end

  assign w_ctr  = w_nwin[HALF_WIN];
  assign w_cidx = r_cnt - IDX_BITS'(HALF_WIN);
  assign w_full = (r_fill == FB'(W-1));

  always_comb begin
    w_peak = (w_ctr >= bus.threshold);
    for (int k = 0; k < HALF_WIN; k++)
      if (w_nwin[k] > w_ctr) w_peak = 1'b0;
    // Strict vs older keeps only the first sample of a plateau
    for (int k = HALF_WIN+1; k < W; k++)
      if (w_nwin[k] >= w_ctr) w_peak = 1'b0;
`ifdef PEAK_DETECT_PROMINENCE_EN
    w_min = w_ctr;
    for (int k = 0; k < W; k++)
      if (w_nwin[k] < w_min) w_min = w_nwin[k];
    if ((w_ctr - w_min) < bus.prominence) w_peak = 1'b0;
`endif
  end

  assign w_fire = bus.in_valid && w_peak &&
                  ((r_state == S_SEARCH) ||
                   ((r_state == S_FILL) && w_full));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < W; k++)
        r_win[k] <= '0;
      r_cnt       <= '0;
      r_fill      <= '0;
      r_hold      <= '0;
      r_state     <= S_FILL;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.in_valid) begin
        for (int k = 0; k < W; k++)
          r_win[k] <= w_nwin[k];
        r_cnt <= r_cnt + IDX_BITS'(1);
        if (w_fire) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_ctr;
          r_out_index <= w_cidx;
          r_hold      <= HB'(REFRACT);
        end
        unique case (r_state)
          S_FILL: begin
            if (w_full)
              r_state <= (w_fire && REFRACT > 0) ?
                         S_HOLD : S_SEARCH;
            else
              r_fill <= r_fill + FB'(1);
          end
          S_SEARCH: begin
            if (w_fire && REFRACT > 0)
              r_state <= S_HOLD;
          end
          S_HOLD: begin
            r_hold <= r_hold - HB'(1);
            if (r_hold == HB'(1))
              r_state <= S_SEARCH;
          end
          default: r_state <= S_FILL;
        endcase
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.busy      = (r_state != S_SEARCH);
endmodule

// File: tb/tb_peak_detect_win.sv
// Directed bench for peak_detect_win: HALF_WIN=1, REFRACT=2, IDX_BITS=4.
module tb_peak_detect_win;
  logic clk;
  logic reset;
  int   nchecks = 0;
  int   nerr    = 0;
  logic [15:0] pkd [$];
  logic [3:0]  pki [$];

  peak_detect_win_if #(.DATA_IN_BITS(16), .IDX_BITS(4)) bus ();

  peak_detect_win #(
    .DATA_IN_BITS(16), .HALF_WIN(1), .REFRACT(2), .IDX_BITS(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    if (bus.out_valid === 1'b1) begin
      pkd.push_back(bus.out_data);
      pki.push_back(bus.out_index);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0, 16'd0);
    step(1'b0, 16'd0);
    reset = 1'b1;
    pkd.delete();
    pki.delete();
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.threshold = '0;
`ifdef PEAK_DETECT_PROMINENCE_EN
    bus.prominence = '0;
`endif
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_index", 32'(bus.out_index), 32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd1);

    // 1,3,2 -> peak 3 at index 1
    step(1'b1, 16'd1);
    step(1'b1, 16'd3);
    chk("t1_early", 32'(bus.out_valid), 32'd0);
    step(1'b1, 16'd2);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data",  32'(bus.out_data),  32'd3);
    chk("t1_index", 32'(bus.out_index), 32'd1);
    step(1'b0, 16'd0);
    chk("t1_pulse", 32'(bus.out_valid), 32'd0);
    chk("t1_hold",  32'(bus.out_data),  32'd3);

    // plateau 1,5,5,2
    do_reset();
    step(1'b1, 16'd1); step(1'b1, 16'd5);
    step(1'b1, 16'd5); step(1'b1, 16'd2);
    step(1'b0, 16'd0);
    chk("plat_n", 32'(pkd.size()), 32'd1);
    if (pkd.size() > 0) begin
      chk("plat_data",  32'(pkd[0]), 32'd5);
      chk("plat_index", 32'(pki[0]), 32'd1);
    end

    // monotonic 4,3,2,1
    do_reset();
    step(1'b1, 16'd4); step(1'b1, 16'd3);
    step(1'b1, 16'd2); step(1'b1, 16'd1);
    step(1'b0, 16'd0);
    chk("mono_n", 32'(pkd.size()), 32'd0);

    // threshold 10
    do_reset();
    bus.threshold = 16'd10;
    step(1'b1, 16'd0); step(1'b1, 16'd9);
    step(1'b1, 16'd0); step(1'b1, 16'd0);
    step(1'b1, 16'd12); step(1'b1, 16'd0);
    step(1'b0, 16'd0);
    bus.threshold = '0;
    chk("thr_n", 32'(pkd.size()), 32'd1);
    if (pkd.size() > 0) begin
      chk("thr_data",  32'(pkd[0]), 32'd12);
      chk("thr_index", 32'(pki[0]), 32'd4);
    end

    // hold-off suppresses the 8
    do_reset();
    step(1'b1, 16'd0); step(1'b1, 16'd7);
    step(1'b1, 16'd0);
    chk("ho_busy0", 32'(bus.busy), 32'd1);
    step(1'b1, 16'd8);
    chk("ho_busy1", 32'(bus.busy), 32'd1);
    step(1'b1, 16'd0);
    chk("ho_free", 32'(bus.busy), 32'd0);
    step(1'b1, 16'd9); step(1'b1, 16'd0);
    step(1'b1, 16'd0); step(1'b0, 16'd0);
    chk("ho_n", 32'(pkd.size()), 32'd2);
    if (pkd.size() == 2) begin
      chk("ho_d0", 32'(pkd[0]), 32'd7);
      chk("ho_i0", 32'(pki[0]), 32'd1);
      chk("ho_d1", 32'(pkd[1]), 32'd9);
      chk("ho_i1", 32'(pki[1]), 32'd5);
    end

    // idle gaps do not disturb the window
    do_reset();
    step(1'b1, 16'd0); step(1'b1, 16'd6);
    for (int i = 0; i < 5; i++) step(1'b0, 16'd99);
    chk("idle_n", 32'(pkd.size()), 32'd0);
    step(1'b1, 16'd1);
    chk("idle_valid", 32'(bus.out_valid), 32'd1);
    chk("idle_data",  32'(bus.out_data),  32'd6);
    chk("idle_index", 32'(bus.out_index), 32'd1);

    // reset during hold-off
    do_reset();
    step(1'b1, 16'd0); step(1'b1, 16'd7);
    step(1'b1, 16'd0); step(1'b1, 16'd0);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    step(1'b1, 16'd9);
    reset = 1'b1;
    pkd.delete(); pki.delete();
    step(1'b0, 16'd0);
    chk("mid_novalid", 32'(bus.out_valid), 32'd0);
    chk("mid_data",    32'(bus.out_data),  32'd0);
    step(1'b1, 16'd2); step(1'b1, 16'd4);
    step(1'b1, 16'd1); step(1'b0, 16'd0);
    chk("mid_n", 32'(pkd.size()), 32'd1);
    if (pkd.size() > 0) begin
      chk("mid_pdata",  32'(pkd[0]), 32'd4);
      chk("mid_pindex", 32'(pki[0]), 32'd1);
    end

    // index wrap with 4-bit counter
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 16'd0);
    step(1'b1, 16'd5);
    step(1'b1, 16'd0);
    step(1'b1, 16'd0); step(1'b1, 16'd0);
    step(1'b1, 16'd0); step(1'b1, 16'd7);
    step(1'b1, 16'd0); step(1'b0, 16'd0);
    chk("wrap_n", 32'(pkd.size()), 32'd2);
    if (pkd.size() == 2) begin
      chk("wrap_d0", 32'(pkd[0]), 32'd5);
      chk("wrap_i0", 32'(pki[0]), 32'd15);
      chk("wrap_d1", 32'(pkd[1]), 32'd7);
      chk("wrap_i1", 32'(pki[1]), 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end
endmodule
